cim_level_scheduler: RTL



---
 rtl/cim_sched_pkg.sv | 15 +
 rtl/cim_rr_arbiter.sv | 37 +++
 rtl/cim_level_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cim_sched_pkg.sv
// Shared types and helpers for the CiM level scheduler.
package cim_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } sched_state_e;

  // Level-index width for a CiM holding hv_dim/2 levels.
  function automatic int unsigned cim_sel_width(input int unsigned hv_dim);
    return $clog2(hv_dim / 2);
  endfunction

endpackage

// File: rtl/cim_rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr_i with wrap, returns one-hot
// grant, winner index and an any-request flag.
module cim_rr_arbiter #(
  parameter int unsigned NumReqs = 4,
  localparam int unsigned IdWidth = $clog2(NumReqs)
) (
  input  logic [NumReqs-1:0] req_i,
  input  logic [IdWidth-1:0] ptr_i,
  output logic [NumReqs-1:0] gnt_o,
  output logic [IdWidth-1:0] idx_o,
  output logic               any_o
);

  int unsigned      cand;
  logic [IdWidth-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NumReqs; i++) begin
      cand = 32'(ptr_i) + i;
      if (cand >= NumReqs) begin
        cand = cand - NumReqs;
      end
      cand_idx = IdWidth'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o           = 1'b1;
        idx_o           = cand_idx;
        gnt_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cim_level_scheduler.sv
// Shares one CiM lookup port among NumReqs requesters: round-robin grant,
// quantize to a level index, valid/ready output. CIM_SCHED_SATURATE_EN selects
// saturating (defined) vs. wrapping (undefined) range limiting.
module cim_level_scheduler
  import cim_sched_pkg::*;
#(
  parameter int unsigned NumReqs     = 4,
  parameter int unsigned ValueWidth  = 16,
  parameter int unsigned HVDimension = 512,
  parameter int unsigned ShiftWidth  = $clog2(ValueWidth),
  localparam int unsigned NumCimLevels = HVDimension / 2,
  localparam int unsigned ImSelWidth   = cim_sel_width(HVDimension),
  localparam int unsigned IdWidth      = $clog2(NumReqs)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReqs-1:0]            req_valid_i,
  input  logic [NumReqs*ValueWidth-1:0] req_value_i,
  output logic [NumReqs-1:0]            req_ready_o,
  input  logic [ValueWidth-1:0]         value_min_i,
  input  logic [ShiftWidth-1:0]         level_shift_i,
  output logic [ImSelWidth-1:0]         cim_sel_o,
  output logic [IdWidth-1:0]            cim_req_id_o,
  output logic                          cim_valid_o,
  input  logic                          cim_ready_i,
  output logic                          busy_o
);

  sched_state_e          state_q, state_d;
  logic [IdWidth-1:0]    ptr_q, ptr_d;
  logic [ValueWidth-1:0] value_q, value_d;
  logic [IdWidth-1:0]    id_q, id_d;
  logic [ValueWidth-1:0] min_q, min_d;
  logic [ShiftWidth-1:0] shift_q, shift_d;
  logic [ImSelWidth-1:0] sel_q, sel_d;
  logic [IdWidth-1:0]    out_id_q, out_id_d;
  logic                  busy_q, busy_d;

  logic [NumReqs-1:0]    gnt;
  logic [IdWidth-1:0]    win_idx;
  logic                  any_req;
  logic                  grant_en;
  logic [ValueWidth-1:0] win_value;

  logic [ValueWidth:0]   diff;
  logic [ValueWidth-1:0] offset;
  logic [ImSelWidth-1:0] lvl_sel;
`ifdef CIM_SCHED_SATURATE_EN
  logic [ValueWidth-1:0] lvl;
`endif

  cim_rr_arbiter #(
    .NumReqs(NumReqs)
  ) u_arb (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (any_req)
  );

  always_comb begin
    win_value = '0;
    for (int unsigned i = 0; i < NumReqs; i++) begin
      if (IdWidth'(i) == win_idx) begin
        win_value = req_value_i[i*ValueWidth +: ValueWidth];
      end
    end
  end

  // Borrow out of the widened subtraction means value < floor.
  always_comb begin
    diff   = {1'b0, value_q} - {1'b0, min_q};
    offset = diff[ValueWidth] ? '0 : diff[ValueWidth-1:0];
`ifdef CIM_SCHED_SATURATE_EN
    lvl     = offset >> shift_q;
    lvl_sel = (lvl > ValueWidth'(NumCimLevels - 1)) ? ImSelWidth'(NumCimLevels - 1)
                                                     : lvl[ImSelWidth-1:0];
`else
    lvl_sel = ImSelWidth'(offset >> shift_q);
`endif
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    value_d     = value_q;
    id_d        = id_q;
    min_d       = min_q;
    shift_d     = shift_q;
    sel_d       = sel_q;
    out_id_d    = out_id_q;
    grant_en    = 1'b0;
    cim_valid_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_en = 1'b1;
          state_d  = CALC;
        end
      end
      CALC: begin
        sel_d    = lvl_sel;
        out_id_d = id_q;
        state_d  = OUT;
      end
      OUT: begin
        cim_valid_o = 1'b1;
        if (cim_ready_i) begin
          if (any_req) begin
            grant_en = 1'b1;
            state_d  = CALC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_en) begin
      ptr_d   = (win_idx == IdWidth'(NumReqs - 1)) ? '0 : win_idx + 1'b1;
      value_d = win_value;
      id_d    = win_idx;
      min_d   = value_min_i;
      shift_d = level_shift_i;
    end

    busy_d = (state_d != IDLE);
    // Suppress the strobe while reset is held so no requester sees a grant.
    req_ready_o = (grant_en && rst_ni) ? gnt : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      value_q  <= '0;
      id_q     <= '0;
      min_q    <= '0;
      shift_q  <= '0;
      sel_q    <= '0;
      out_id_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      value_q  <= value_d;
      id_q     <= id_d;
      min_q    <= min_d;
      shift_q  <= shift_d;
      sel_q    <= sel_d;
      out_id_q <= out_id_d;
      busy_q   <= busy_d;
    end
  end

  assign cim_sel_o    = sel_q;
  assign cim_req_id_o = out_id_q;
  assign busy_o       = busy_q;

endmodule
